// File: rtl/mem_mmio_subsys.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_mmio_subsys                                                |
// | Purpose : Unified word RAM plus memory-mapped I/O for the multi-cycle    |
// |           core: free-running cycle counter, debug-output FIFO drained by |
// |           a valid/ready sink, dropped-push counter, and an optional      |
// |           timer-compare register with sticky interrupt.                  |
// | Options : define MMIO_TIMER_CMP_EN to build the CMP register and irq.    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mem_mmio_subsys #(
  parameter int          MEM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        dbg_valid,
  output logic [31:0] dbg_data,
  input  logic        dbg_ready,
  output logic        irq
);

  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  // Word index of each register relative to MMIO_BASE
  localparam logic [29:0] SEL_CYCLE = 30'd0;
  localparam logic [29:0] SEL_DBGTX = 30'd1;
  localparam logic [29:0] SEL_DROP  = 30'd2;
  localparam logic [29:0] SEL_CMP   = 30'd3;

  localparam logic [PTR_W:0] PTR_ONE  = 1;
  localparam logic [31:0]    DROP_MAX = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------- decode
  logic              is_mmio;
  logic [29:0]       reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_ram;
  logic              wr_cycle;
  logic              wr_dbgtx;
  logic              wr_drop;

  assign is_mmio  = (Adr >= MMIO_BASE);
  assign reg_sel  = Adr[31:2] - MMIO_BASE[31:2];
  // Upper address bits below MMIO_BASE are ignored, so RAM aliases.
  assign ram_idx  = Adr[RAM_AW+1:2];
  assign wr_ram   = MemWrite && !is_mmio;
  assign wr_cycle = MemWrite && is_mmio && (reg_sel == SEL_CYCLE);
  assign wr_dbgtx = MemWrite && is_mmio && (reg_sel == SEL_DBGTX);
  assign wr_drop  = MemWrite && is_mmio && (reg_sel == SEL_DROP);

  // ---------------------------------------------------------------- RAM
  logic [31:0] ram [MEM_WORDS];

  // Word store; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= WriteData;
  end

  // ---------------------------------------------------------------- cycle counter
  logic [31:0] cycle;

  // Free-running counter; a software write replaces the increment that cycle
  always_ff @(posedge clk) begin
    if (reset)         cycle <= '0;
    else if (wr_cycle) cycle <= WriteData;
    else               cycle <= cycle + 32'd1;
  end

  // ---------------------------------------------------------------- debug FIFO
  logic [31:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           fifo_empty;
  logic           fifo_full;
  logic           do_pop;
  logic           do_push;
  logic           do_drop;

  // Extra MSB on each pointer distinguishes full from empty
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop     = !fifo_empty && dbg_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts
  assign do_push    = wr_dbgtx && (!fifo_full || do_pop);
  assign do_drop    = wr_dbgtx && fifo_full && !do_pop;

  assign dbg_valid  = !fifo_empty;
  assign dbg_data   = fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];

  // Entry storage; a push coinciding with reset is lost
  always_ff @(posedge clk) begin
    if (!reset && do_push) fifo_mem[wr_ptr[PTR_W-1:0]] <= WriteData;
  end

  // Pointer update; reset empties the FIFO in one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------- drop counter
  logic [31:0] drop;

  // Saturating count of discarded pushes; a clear beats a same-cycle drop
  always_ff @(posedge clk) begin
    if (reset)                             drop <= '0;
    else if (wr_drop)                      drop <= '0;
    else if (do_drop && drop != DROP_MAX)  drop <= drop + 32'd1;
  end

  // ---------------------------------------------------------------- timer compare
`ifdef MMIO_TIMER_CMP_EN
  logic        wr_cmp;
  logic [31:0] cmp;
  logic        irq_q;

  assign wr_cmp = MemWrite && is_mmio && (reg_sel == SEL_CMP);
  assign irq    = irq_q;

  // Sticky match flag on registered CYCLE/CMP; a CMP write reloads and clears
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp   <= '0;
      irq_q <= 1'b0;
    end else if (wr_cmp) begin
      cmp   <= WriteData;
      irq_q <= 1'b0;
    end else if (cycle == cmp) begin
      irq_q <= 1'b1;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------- read mux
  // Side-effect-free combinational read of RAM or MMIO
  always_comb begin
    ReadData = '0;
    if (!is_mmio) begin
      ReadData = ram[ram_idx];
    end else begin
      case (reg_sel)
        SEL_CYCLE: ReadData = cycle;
        SEL_DBGTX: ReadData = {30'b0, fifo_full, fifo_empty};
        SEL_DROP:  ReadData = drop;
`ifdef MMIO_TIMER_CMP_EN
        SEL_CMP:   ReadData = cmp;
`endif
        default:   ReadData = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_mmio_subsys.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mem_mmio_subsys                                             |
// | Purpose : Self-checking bench for mem_mmio_subsys: directed scenarios    |
// |           followed by random traffic against a queue-based model.        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_mem_mmio_subsys;

  localparam int          MEM_WORDS  = 64;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Adr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        dbg_valid;
  logic [31:0] dbg_data;
  logic        dbg_ready = 1'b0;
  logic        irq;

  mem_mmio_subsys #(
    .MEM_WORDS (MEM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .Adr      (Adr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .dbg_valid(dbg_valid),
    .dbg_data (dbg_data),
    .dbg_ready(dbg_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_cycle = '0;
  logic [31:0] m_drop  = '0;
  logic [31:0] m_cmp   = '0;
  logic        m_irq   = 1'b0;
  logic [31:0] m_q[$];
  logic [31:0] m_ram [MEM_WORDS];
  bit          m_vld [MEM_WORDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ram_slot(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] sel;
    if (a < MMIO_BASE) return m_ram[ram_slot(a)];
    sel = (a - MMIO_BASE) >> 2;
    case (sel)
      32'd0:   return m_cycle;
      32'd1:   return {30'b0, (m_q.size() == FIFO_DEPTH), (m_q.size() == 0)};
      32'd2:   return m_drop;
`ifdef MMIO_TIMER_CMP_EN
      32'd3:   return m_cmp;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Apply one cycle of inputs, predict its effect, advance past the edge
  task automatic cyc(input logic r, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic rdy);
    logic [31:0] nc, nd, ncmp, sel;
    logic        nirq, is_m, popped, preq;
    int          sz;
    reset = r; MemWrite = we; Adr = a; WriteData = wd; dbg_ready = rdy;
    sz = m_q.size();
    nc = m_cycle; nd = m_drop; ncmp = m_cmp; nirq = m_irq;
    if (r) begin
      nc = '0; nd = '0; ncmp = '0; nirq = 1'b0;
      m_q.delete();
    end else begin
      is_m   = (a >= MMIO_BASE);
      sel    = (a - MMIO_BASE) >> 2;
      popped = (sz > 0) && rdy;
      preq   = we && is_m && (sel == 32'd1);
      nc     = (we && is_m && sel == 32'd0) ? wd : m_cycle + 32'd1;
      if (we && is_m && sel == 32'd2) nd = '0;
      else if (preq && sz == FIFO_DEPTH && !popped && m_drop != 32'hFFFF_FFFF) nd = m_drop + 32'd1;
`ifdef MMIO_TIMER_CMP_EN
      nirq = m_irq || (m_cycle == m_cmp);
      if (we && is_m && sel == 32'd3) begin ncmp = wd; nirq = 1'b0; end
`endif
      if (popped) void'(m_q.pop_front());
      if (preq && (sz < FIFO_DEPTH || popped)) m_q.push_back(wd);
    end
    if (we && a < MMIO_BASE) begin
      m_ram[ram_slot(a)] = wd;
      m_vld[ram_slot(a)] = 1'b1;
    end
    @(posedge clk);
    #1;
    m_cycle = nc; m_drop = nd; m_cmp = ncmp; m_irq = nirq;
    MemWrite = 1'b0;
  endtask

  // Read an address between edges and compare every output with the model
  task automatic probe(input string tag, input logic [31:0] a);
    Adr = a; MemWrite = 1'b0;
    #1;
    check({tag, "/valid"}, {31'b0, dbg_valid}, {31'b0, m_q.size() != 0});
    check({tag, "/data"}, dbg_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
    check({tag, "/irq"}, {31'b0, irq}, {31'b0, m_irq});
    if (a >= MMIO_BASE || m_vld[ram_slot(a)])
      check({tag, "/rdata"}, ReadData, model_read(a));
  endtask

  initial begin
    logic        r, we, rdy;
    logic [31:0] a, wd;
    int          kind;

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    probe("rst_cycle", MMIO_BASE);
    check("rst_cycle_zero", ReadData, 32'd0);
    probe("rst_status", MMIO_BASE + 4);
    check("rst_status_empty", ReadData, 32'd1);
    probe("rst_cmp", MMIO_BASE + 12);

    // RAM write/read and aliasing
    cyc(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    probe("ram", 32'h10);
    check("ram_const", ReadData, 32'hDEAD_BEEF);
    probe("ram_alias", 32'h10 + 4 * MEM_WORDS);
    check("ram_alias_const", ReadData, 32'hDEAD_BEEF);

    // Cycle counter and wrap
    cyc(1, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    probe("cyc10", MMIO_BASE);
    check("cyc10_const", ReadData, 32'd10);
    cyc(0, 1, MMIO_BASE, 32'hFFFF_FFFE, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    probe("cyc_wrap", MMIO_BASE);
    check("cyc_wrap_const", ReadData, 32'd0);

    // Overfill with sink stalled, then drain
    for (int i = 1; i <= 10; i++) cyc(0, 1, MMIO_BASE + 4, i, 0);
    probe("full_status", MMIO_BASE + 4);
    check("full_status_const", ReadData, 32'd2);
    probe("full_drop", MMIO_BASE + 8);
    check("full_drop_const", ReadData, 32'd2);
    check("full_head_const", dbg_data, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      probe("drain", MMIO_BASE + 4);
      check("drain_order", dbg_data, i);
      cyc(0, 0, 0, 0, 1);
    end
    probe("drained", MMIO_BASE + 4);
    check("drained_valid", {31'b0, dbg_valid}, 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 8; i++) cyc(0, 1, MMIO_BASE + 4, 100 + i, 0);
    cyc(0, 1, MMIO_BASE + 4, 32'd99, 1);
    probe("pushpop_drop", MMIO_BASE + 8);
    check("pushpop_drop_const", ReadData, 32'd2);
    check("pushpop_head_const", dbg_data, 32'd102);
    repeat (7) cyc(0, 0, 0, 0, 1);
    probe("pushpop_last", MMIO_BASE + 4);
    check("pushpop_last_const", dbg_data, 32'd99);
    cyc(0, 0, 0, 0, 1);
    probe("pushpop_empty", MMIO_BASE + 4);

    // Drop clear
    cyc(0, 1, MMIO_BASE + 8, 32'h1234, 0);
    probe("drop_clear", MMIO_BASE + 8);
    check("drop_clear_const", ReadData, 32'd0);

    // Reset with words queued
    for (int i = 1; i <= 3; i++) cyc(0, 1, MMIO_BASE + 4, 32'h50 + i, 0);
    cyc(1, 1, MMIO_BASE + 4, 32'h77, 0);
    probe("rst_mid_status", MMIO_BASE + 4);
    check("rst_mid_status_const", ReadData, 32'd1);
    check("rst_mid_valid", {31'b0, dbg_valid}, 32'd0);
    probe("rst_mid_cycle", MMIO_BASE);
    check("rst_mid_cycle_const", ReadData, 32'd0);
    probe("rst_mid_drop", MMIO_BASE + 8);

`ifdef MMIO_TIMER_CMP_EN
    // Timer compare
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, MMIO_BASE + 12, 32'd20, 0);
    probe("cmp_loaded", MMIO_BASE + 12);
    for (int i = 0; i < 30 && m_cycle != 32'd21; i++) begin
      check("cmp_low", {31'b0, irq}, 32'd0);
      cyc(0, 0, 0, 0, 0);
    end
    probe("cmp_hit", MMIO_BASE);
    check("cmp_hit_const", {31'b0, irq}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    check("cmp_hold", {31'b0, irq}, 32'd1);
    cyc(0, 1, MMIO_BASE + 12, 32'h1000, 0);
    probe("cmp_clear", MMIO_BASE + 12);
    check("cmp_clear_const", {31'b0, irq}, 32'd0);
`endif

    // Random traffic
    cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      r    = ($urandom_range(0, 99) == 0);
      kind = $urandom_range(0, 9);
      we   = 1'b0;
      wd   = $urandom;
      a    = 32'd0;
      if (kind <= 2) begin
        we = 1'b1;
        a  = $urandom_range(0, 4095);
      end else if (kind <= 5) begin
        we = 1'b1;
        a  = MMIO_BASE + 32'd4 + $urandom_range(0, 3);
      end else if (kind == 6) begin
        we = 1'b1;
        a  = MMIO_BASE + $urandom_range(0, 31);
      end else begin
        a  = $urandom_range(0, 4095);
      end
      rdy = ($urandom_range(0, 2) == 0);
      cyc(r, we, a, wd, rdy);
      if ($urandom_range(0, 1) == 0) probe("rand_ram", $urandom_range(0, 4095));
      else                           probe("rand_mmio", MMIO_BASE + $urandom_range(0, 31));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
